ls_sched: RTL and testbench
===========================

LS_SCHED -- requirements
Module: ls_sched

Interface
REQ-001 Parameters SHALL be: DEPTH, 4, number of queue entries (power of 2, 2..16); MEM_BYTES, 128, byte size of the data cache array; TMO_CYC, 15, load-wait cycles before timeout.
REQ-002 Clk  in  1  rising-edge clock.
REQ-003 Rst  in  1  asynchronous active-high reset.
REQ-004 Disp_Valid  in  1  dispatch offers one load/store entry.
REQ-005 Disp_Opcode  in  1  1=load, 0=store.
REQ-006 Disp_Address  in  32  byte address.
REQ-007 Disp_Data  in  32  store data.
REQ-008 Disp_Tag  in  5  ROB/rename tag.
REQ-009 Disp_Full  out  1  queue cannot accept an entry this cycle.
REQ-010 Flush  in  1  discard all queued entries.
REQ-011 Cache_Ready_Out, Cache_Opcode, Cache_Address[31:0], Cache_Data[31:0], Cache_Tag[4:0]  out  head entry presented to the data cache.
REQ-012 Cache_Issue_In  in  1  data cache consumed the head entry.
REQ-013 Err_Pulse  out  1  one-cycle pulse: entry rejected by bounds check.
REQ-014 Tmo_Pulse  out  1  one-cycle pulse: head load waited TMO_CYC cycles.
REQ-015 Ld_Count, St_Count  out  16 each  retired load/store counters, wrapping.

Function
REQ-016 Queue SHALL be an in-order FIFO; entries leave only from the head, in dispatch order.
REQ-017 Enqueue SHALL occur on a rising edge when Disp_Valid=1 and Disp_Full=0; Disp_Valid with Disp_Full=1 SHALL be ignored (no entry written).
REQ-018 Disp_Full SHALL equal (occupancy==DEPTH), combinational from registered state only.
REQ-019 Cache_Ready_Out SHALL be 1 iff occupancy>0 and state is ACTIVE; Cache_* fields SHALL show head contents, zero when empty.
REQ-020 Dequeue SHALL occur on the edge where Cache_Ready_Out=1 and Cache_Issue_In=1; Cache_Issue_In while Cache_Ready_Out=0 SHALL be ignored.
REQ-021 Simultaneous enqueue and dequeue SHALL keep occupancy unchanged and SHALL be legal when full (full queue with dequeue still rejects enqueue that cycle because Disp_Full=1).
REQ-022 An entry enqueued into an empty queue SHALL be presented on the next cycle (latency 1); no bypass.
REQ-023 Pointers SHALL wrap modulo DEPTH; occupancy SHALL be log2(DEPTH)+1 bits.
REQ-024 FSM states: IDLE (empty), ACTIVE (head presented), FLUSH (one cycle, Cache_Ready_Out=0).
REQ-025 Transitions: IDLE->ACTIVE on enqueue; ACTIVE->IDLE when last entry dequeued without enqueue; any->FLUSH on Flush=1; FLUSH->IDLE unconditionally.
REQ-026 Flush SHALL win over simultaneous enqueue and dequeue: both dropped, occupancy 0, counters not incremented.
REQ-027 Wait counter SHALL count cycles head is a load with Cache_Ready_Out=1 and Cache_Issue_In=0; at TMO_CYC Tmo_Pulse=1 for one cycle, counter saturates until head changes; resets on dequeue or flush. Entry is not dropped.
REQ-028 Ld_Count/St_Count SHALL increment by 1 on each dequeue of a load/store respectively, wrapping 0xFFFF->0x0000.

Reset
REQ-029 Rst=1 SHALL immediately clear pointers, occupancy, wait counter, counters to 0, state to IDLE, all outputs to 0 (Disp_Full=0), regardless of Clk.
REQ-030 Reset mid-operation SHALL discard all entries; first post-reset enqueue SHALL be accepted on the first rising edge after Rst falls.

Configuration
REQ-031 Macro LS_BOUNDS_CHECK_EN defined: entries with Disp_Address+3 >= MEM_BYTES or Disp_Address[1:0]!=0 SHALL not be enqueued and SHALL raise Err_Pulse the following cycle.
REQ-032 LS_BOUNDS_CHECK_EN undefined: all addresses SHALL be enqueued and Err_Pulse SHALL be tied 0.

Verification
REQ-033 Reset, enqueue store addr 0x10 data 0x0000000F tag 3, Cache_Issue_In=1 -> Cache_Ready_Out=1 one cycle after enqueue, St_Count=1, state IDLE.
REQ-034 Enqueue 5 entries back-to-back with Cache_Issue_In=0 (DEPTH=4) -> Disp_Full=1 after 4th, 5th dropped, head tags in order 0,1,2,3.
REQ-035 Full queue, simultaneous Disp_Valid and Cache_Issue_In -> dequeue only, occupancy 3; next cycle enqueue accepted, occupancy 4.
REQ-036 Head load tag 7 held 15 cycles with Cache_Issue_In=0 -> single Tmo_Pulse, entry remains; Cache_Issue_In=1 -> Ld_Count=1.
REQ-037 Three entries queued, Flush with concurrent enqueue/dequeue -> FLUSH one cycle, then IDLE, occupancy 0, counters unchanged.
REQ-038 LS_BOUNDS_CHECK_EN defined, enqueue addr 0x7E -> not queued, Err_Pulse=1 one cycle; undefined -> queued, Err_Pulse=0.

Source files
------------

// File: rtl/ls_sched.sv
// rtl/ls_sched.sv - in-order load/store queue presenting its head entry to the data cache
// Optional feature macro LS_BOUNDS_CHECK_EN: reject out-of-range or misaligned addresses at dispatch.
module ls_sched #(
    parameter int DEPTH     = 4,
    parameter int MEM_BYTES = 128,
    parameter int TMO_CYC   = 15
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Disp_Valid,
    input  logic        Disp_Opcode,
    input  logic [31:0] Disp_Address,
    input  logic [31:0] Disp_Data,
    input  logic [4:0]  Disp_Tag,
    output logic        Disp_Full,
    input  logic        Flush,
    output logic        Cache_Ready_Out,
    output logic        Cache_Opcode,
    output logic [31:0] Cache_Address,
    output logic [31:0] Cache_Data,
    output logic [4:0]  Cache_Tag,
    input  logic        Cache_Issue_In,
    output logic        Err_Pulse,
    output logic        Tmo_Pulse,
    output logic [15:0] Ld_Count,
    output logic [15:0] St_Count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WW = (TMO_CYC > 1) ? $clog2(TMO_CYC + 1) : 1;
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [WW-1:0] TMO_MAX  = WW'(TMO_CYC);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          tmo_q, tmo_d;
    logic [15:0]   ld_cnt_q, ld_cnt_d;
    logic [15:0]   st_cnt_q, st_cnt_d;

    logic          mem_op   [DEPTH];
    logic [31:0]   mem_addr [DEPTH];
    logic [31:0]   mem_data [DEPTH];
    logic [4:0]    mem_tag  [DEPTH];

    logic          addr_bad;
    logic          not_empty;
    logic          enq;
    logic          deq;
    logic          head_op;

`ifdef LS_BOUNDS_CHECK_EN
    logic [32:0]   addr_end;
    logic          err_q, err_d;

    // Last byte of the word must fall inside the array; carry bit keeps wrap-around addresses out.
    assign addr_end  = {1'b0, Disp_Address} + 33'd3;
    assign addr_bad  = (addr_end >= 33'(MEM_BYTES)) || (Disp_Address[1:0] != 2'b00);
    assign err_d     = Disp_Valid && !Disp_Full && !Flush && addr_bad;
    assign Err_Pulse = err_q;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`else
    assign addr_bad  = 1'b0;
    assign Err_Pulse = 1'b0;
`endif

    assign not_empty       = (count_q != '0);
    assign Disp_Full       = (count_q == FULL_CNT);
    assign Cache_Ready_Out = not_empty && (state_q == ACTIVE);
    assign enq             = Disp_Valid && !Disp_Full && !Flush && !addr_bad;
    assign deq             = Cache_Ready_Out && Cache_Issue_In && !Flush;
    assign head_op         = mem_op[rd_ptr_q];

    assign Cache_Opcode  = not_empty ? head_op            : 1'b0;
    assign Cache_Address = not_empty ? mem_addr[rd_ptr_q] : 32'd0;
    assign Cache_Data    = not_empty ? mem_data[rd_ptr_q] : 32'd0;
    assign Cache_Tag     = not_empty ? mem_tag[rd_ptr_q]  : 5'd0;
    assign Tmo_Pulse     = tmo_q;
    assign Ld_Count      = ld_cnt_q;
    assign St_Count      = st_cnt_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (enq || not_empty) begin
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (deq && !enq && (count_q == (AW + 1)'(1))) begin
                    state_d = IDLE;
                end
            end
            FLUSH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (Flush) begin
            state_d = FLUSH;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ld_cnt_d = ld_cnt_q;
        st_cnt_d = st_cnt_q;
        if (Flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
                if (head_op) begin
                    ld_cnt_d = ld_cnt_q + 16'd1;
                end else begin
                    st_cnt_d = st_cnt_q + 16'd1;
                end
            end
            if (enq && !deq) begin
                count_d = count_q + (AW + 1)'(1);
            end else if (deq && !enq) begin
                count_d = count_q - (AW + 1)'(1);
            end
        end
    end

    // Wait counter saturates at TMO_MAX so the timeout fires once per head entry.
    always_comb begin
        wait_d = wait_q;
        tmo_d  = 1'b0;
        if (Flush || deq) begin
            wait_d = '0;
        end else if (Cache_Ready_Out && head_op && !Cache_Issue_In && (wait_q != TMO_MAX)) begin
            wait_d = wait_q + WW'(1);
            tmo_d  = (wait_q == TMO_MAX - WW'(1));
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            wait_q   <= '0;
            tmo_q    <= 1'b0;
            ld_cnt_q <= 16'd0;
            st_cnt_q <= 16'd0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            wait_q   <= wait_d;
            tmo_q    <= tmo_d;
            ld_cnt_q <= ld_cnt_d;
            st_cnt_q <= st_cnt_d;
        end
    end

    // Entry storage needs no reset: outputs are masked while the queue is empty.
    always_ff @(posedge Clk) begin
        if (enq) begin
            mem_op[wr_ptr_q]   <= Disp_Opcode;
            mem_addr[wr_ptr_q] <= Disp_Address;
            mem_data[wr_ptr_q] <= Disp_Data;
            mem_tag[wr_ptr_q]  <= Disp_Tag;
        end
    end

endmodule

// File: tb/tb_ls_sched.sv
// tb/tb_ls_sched.sv - self-checking bench for ls_sched
// Vector table plus hand sequences; a scoreboard queue holds entries expected at the cache port.
module tb_ls_sched;

    localparam int DEPTH     = 4;
    localparam int MEM_BYTES = 128;
    localparam int TMO_CYC   = 15;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Disp_Valid;
    logic        Disp_Opcode;
    logic [31:0] Disp_Address;
    logic [31:0] Disp_Data;
    logic [4:0]  Disp_Tag;
    logic        Disp_Full;
    logic        Flush;
    logic        Cache_Ready_Out;
    logic        Cache_Opcode;
    logic [31:0] Cache_Address;
    logic [31:0] Cache_Data;
    logic [4:0]  Cache_Tag;
    logic        Cache_Issue_In;
    logic        Err_Pulse;
    logic        Tmo_Pulse;
    logic [15:0] Ld_Count;
    logic [15:0] St_Count;

    ls_sched #(.DEPTH(DEPTH), .MEM_BYTES(MEM_BYTES), .TMO_CYC(TMO_CYC)) dut (
        .Clk(Clk), .Rst(Rst),
        .Disp_Valid(Disp_Valid), .Disp_Opcode(Disp_Opcode), .Disp_Address(Disp_Address),
        .Disp_Data(Disp_Data), .Disp_Tag(Disp_Tag), .Disp_Full(Disp_Full), .Flush(Flush),
        .Cache_Ready_Out(Cache_Ready_Out), .Cache_Opcode(Cache_Opcode), .Cache_Address(Cache_Address),
        .Cache_Data(Cache_Data), .Cache_Tag(Cache_Tag), .Cache_Issue_In(Cache_Issue_In),
        .Err_Pulse(Err_Pulse), .Tmo_Pulse(Tmo_Pulse), .Ld_Count(Ld_Count), .St_Count(St_Count)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic        op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [4:0]  tag;
    } ent_t;

    typedef struct {
        logic        v;
        logic        op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [4:0]  tag;
        logic        iss;
        logic        fl;
        logic        exp_full;
        logic        exp_ready;
    } vec_t;

    int   errors = 0;
    int   checks = 0;
    ent_t sb[$];
    int   m_occ, m_st, m_w, m_ld, m_st_cnt;
    vec_t vt[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_occ = 0; m_st = 0; m_w = 0; m_ld = 0; m_st_cnt = 0;
        sb.delete();
    endtask

    task automatic do_reset();
        Rst = 1'b1; Disp_Valid = 1'b0; Disp_Opcode = 1'b0; Disp_Address = 32'd0;
        Disp_Data = 32'd0; Disp_Tag = 5'd0; Flush = 1'b0; Cache_Issue_In = 1'b0;
        #1;
        chk("rst_full", Disp_Full, 1'b0);
        chk("rst_ready", Cache_Ready_Out, 1'b0);
        chk("rst_tag", Cache_Tag, 5'd0);
        chk("rst_ld", Ld_Count, 16'd0);
        chk("rst_st", St_Count, 16'd0);
        chk("rst_err", Err_Pulse, 1'b0);
        chk("rst_tmo", Tmo_Pulse, 1'b0);
        @(posedge Clk); #1;
        Rst = 1'b0;
        model_reset();
    endtask

    task automatic step(input logic v, input logic op, input logic [31:0] a, input logic [31:0] d,
                        input logic [4:0] t, input logic iss, input logic fl);
        logic bad, enq, deq, ready, exp_err, exp_tmo;
        ent_t e;
        Disp_Valid = v; Disp_Opcode = op; Disp_Address = a; Disp_Data = d; Disp_Tag = t;
        Cache_Issue_In = iss; Flush = fl;
        bad = 1'b0;
`ifdef LS_BOUNDS_CHECK_EN
        bad = (({1'b0, a} + 33'd3) >= 33'(MEM_BYTES)) || (a[1:0] != 2'b00);
`endif
        ready   = (m_occ > 0) && (m_st == 1);
        enq     = v && (m_occ < DEPTH) && !fl && !bad;
        deq     = ready && iss && !fl;
        exp_err = v && (m_occ < DEPTH) && !fl && bad;
        exp_tmo = 1'b0;
        if (m_occ == 0) begin
            chk("empty_addr", Cache_Address, 32'd0);
            chk("empty_tag", Cache_Tag, 5'd0);
        end
        if (fl || deq) begin
            m_w = 0;
        end else if (ready && sb[0].op && !iss && m_w < TMO_CYC) begin
            m_w++;
            exp_tmo = (m_w == TMO_CYC);
        end
        if (deq) begin
            e = sb.pop_front();
            chk("head_tag", Cache_Tag, e.tag);
            chk("head_addr", Cache_Address, e.addr);
            chk("head_data", Cache_Data, e.data);
            chk("head_op", Cache_Opcode, e.op);
            if (e.op) m_ld = (m_ld + 1) & 16'hFFFF;
            else      m_st_cnt = (m_st_cnt + 1) & 16'hFFFF;
        end
        if (enq) sb.push_back('{op: op, addr: a, data: d, tag: t});
        @(posedge Clk); #1;
        if (fl) begin
            m_occ = 0; m_st = 2; sb.delete();
        end else begin
            m_occ = m_occ + int'(enq) - int'(deq);
            case (m_st)
                0: if (enq) m_st = 1;
                1: if (m_occ == 0) m_st = 0;
                default: m_st = 0;
            endcase
        end
        chk("full", Disp_Full, m_occ == DEPTH);
        chk("ready", Cache_Ready_Out, (m_occ > 0) && (m_st == 1));
        chk("ld_count", Ld_Count, m_ld[15:0]);
        chk("st_count", St_Count, m_st_cnt[15:0]);
        chk("err_pulse", Err_Pulse, exp_err);
        chk("tmo_pulse", Tmo_Pulse, exp_tmo);
        Disp_Valid = 1'b0; Flush = 1'b0;
    endtask

    task automatic idle(input logic iss);
        step(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, iss, 1'b0);
    endtask

    initial begin
        int tmo_cnt;
        // Fill to full, drop the fifth, dequeue while full, refill, drain.
        vt[0]  = '{1'b1, 1'b0, 32'h40, 32'hA0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        vt[1]  = '{1'b1, 1'b0, 32'h44, 32'hA1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1};
        vt[2]  = '{1'b1, 1'b1, 32'h48, 32'hA2, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1};
        vt[3]  = '{1'b1, 1'b0, 32'h4C, 32'hA3, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1};
        vt[4]  = '{1'b1, 1'b0, 32'h50, 32'hA4, 5'd4, 1'b0, 1'b0, 1'b1, 1'b1};
        vt[5]  = '{1'b1, 1'b0, 32'h54, 32'hA5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[6]  = '{1'b1, 1'b0, 32'h58, 32'hA6, 5'd6, 1'b0, 1'b0, 1'b1, 1'b1};
        vt[7]  = '{1'b0, 1'b0, 32'h00, 32'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[8]  = '{1'b0, 1'b0, 32'h00, 32'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[9]  = '{1'b0, 1'b0, 32'h00, 32'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[10] = '{1'b0, 1'b0, 32'h00, 32'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0};

        do_reset();

        // Single store, issue held high: presented after one cycle, retired next.
        step(1'b1, 1'b0, 32'h10, 32'h0000000F, 5'd3, 1'b1, 1'b0);
        chk("s1_ready", Cache_Ready_Out, 1'b1);
        chk("s1_tag", Cache_Tag, 5'd3);
        idle(1'b1);
        chk("s1_st", St_Count, 16'd1);
        chk("s1_idle", Cache_Ready_Out, 1'b0);

        do_reset();
        for (int i = 0; i < 11; i++) begin
            step(vt[i].v, vt[i].op, vt[i].addr, vt[i].data, vt[i].tag, vt[i].iss, vt[i].fl);
            chk($sformatf("vec%0d_full", i), Disp_Full, vt[i].exp_full);
            chk($sformatf("vec%0d_ready", i), Cache_Ready_Out, vt[i].exp_ready);
        end
        chk("tbl_st", St_Count, 16'd4);
        chk("tbl_ld", Ld_Count, 16'd1);

        // Asynchronous reset mid-operation.
        step(1'b1, 1'b0, 32'h60, 32'hB0, 5'd9, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'h64, 32'hB1, 5'd10, 1'b0, 1'b0);
        #2 Rst = 1'b1;
        #1;
        chk("arst_ready", Cache_Ready_Out, 1'b0);
        chk("arst_tag", Cache_Tag, 5'd0);
        chk("arst_st", St_Count, 16'd0);
        chk("arst_ld", Ld_Count, 16'd0);
        @(posedge Clk); #1;
        Rst = 1'b0;
        model_reset();
        step(1'b1, 1'b0, 32'h68, 32'hB2, 5'd11, 1'b0, 1'b0);
        chk("arst_first_tag", Cache_Tag, 5'd11);
        idle(1'b1);

        // Load timeout: one pulse, entry kept, then retired.
        do_reset();
        step(1'b1, 1'b1, 32'h20, 32'hC0, 5'd7, 1'b0, 1'b0);
        tmo_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            idle(1'b0);
            if (Tmo_Pulse) tmo_cnt++;
        end
        chk("tmo_pulses", tmo_cnt, 1);
        chk("tmo_kept_tag", Cache_Tag, 5'd7);
        idle(1'b1);
        chk("tmo_ld", Ld_Count, 16'd1);

        // Flush beats concurrent enqueue and dequeue.
        do_reset();
        step(1'b1, 1'b0, 32'h00, 32'hD0, 5'd8, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'h04, 32'hD1, 5'd9, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'h08, 32'hD2, 5'd10, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'h0C, 32'hD3, 5'd11, 1'b1, 1'b1);
        chk("fl_ready", Cache_Ready_Out, 1'b0);
        chk("fl_st", St_Count, 16'd0);
        chk("fl_ld", Ld_Count, 16'd0);
        idle(1'b0);
        chk("fl_idle_ready", Cache_Ready_Out, 1'b0);
        step(1'b1, 1'b0, 32'h14, 32'hD4, 5'd12, 1'b0, 1'b0);
        chk("fl_after_tag", Cache_Tag, 5'd12);
        idle(1'b1);

        // Out-of-range address handling depends on build.
        do_reset();
        step(1'b1, 1'b0, 32'h7E, 32'hE0, 5'd13, 1'b0, 1'b0);
`ifdef LS_BOUNDS_CHECK_EN
        chk("bnd_err", Err_Pulse, 1'b1);
        chk("bnd_ready", Cache_Ready_Out, 1'b0);
        idle(1'b0);
        chk("bnd_err_clr", Err_Pulse, 1'b0);
`else
        chk("bnd_err", Err_Pulse, 1'b0);
        chk("bnd_ready", Cache_Ready_Out, 1'b1);
        chk("bnd_addr", Cache_Address, 32'h7E);
        idle(1'b1);
`endif
        step(1'b1, 1'b0, 32'h7C, 32'hE1, 5'd14, 1'b0, 1'b0);
        chk("bnd_edge_tag", Cache_Tag, 5'd14);
        idle(1'b1);
        idle(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
